fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
//
// Walks each fetch through IDLE -> REQ -> (WAIT)* -> LOAD -> HOLD. It latches
// the fetch address and holds a memory read request until the memory
// acknowledges. It then pulses the instruction-register load and PC advance,
// and presents the instruction to decode until decode accepts it.
//
// Build option: define FETCH_TIMEOUT_EN to bound the memory wait. After
// TIMEOUT_CYCLES cycles in REQ/WAIT with no mem_ack, the read is abandoned and
// the sticky fetch_err flag is raised. The controller then stays in IDLE until
// reset. Without the macro, fetch_err is tied low and a read may wait forever.
//
// Handshake (decode side): an instruction transfers on a rising edge where
// instr_valid and dec_ready are both 1. instr_valid stays 1 until that edge
// and does not depend combinationally on dec_ready. dec_ready is ignored
// while instr_valid is 0.

module fetch_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              instr_valid,
    input  logic              dec_ready,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t state;

    // A zero-cycle memory-wait limit would abandon every read before it can
    // be acknowledged, so reject it when the design is built.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    // launch_ok gates every new fetch. Once a read has timed out, no further
    // fetch may start until reset.
    logic launch_ok;

`ifdef FETCH_TIMEOUT_EN
    // wait_cnt only needs to hold values 0 .. TIMEOUT_CYCLES-1.
    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    // Flag the cycle that would be the TIMEOUT_CYCLES-th unacknowledged cycle.
    assign timeout_hit = (int'(wait_cnt) + 1) >= TIMEOUT_CYCLES;
    assign launch_ok   = ~fetch_err;
`else
    assign launch_ok   = 1'b1;
    assign fetch_err   = 1'b0;
`endif

    // Main sequencer. All outputs are registered and decoded from the state
    // being entered, so each output is valid for the whole cycle of its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mem_req     <= 1'b0;
            ir_load     <= 1'b0;
            pc_inc      <= 1'b0;
            instr_valid <= 1'b0;
            mem_addr    <= '0;
            fetch_cnt   <= '0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            // ir_load and pc_inc are single-cycle pulses, asserted only on
            // entry to LOAD.
            ir_load <= 1'b0;
            pc_inc  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // mem_ack and dec_ready have no meaning here. Only stall
                    // (and a latched error) decide whether to start a fetch.
                    if (!stall && launch_ok) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_in;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                S_REQ, S_WAIT: begin
                    // The read is outstanding. stall cannot cancel it.
                    // mem_addr holds the address latched at launch.
                    if (mem_ack) begin
                        state     <= S_LOAD;
                        mem_req   <= 1'b0;
                        ir_load   <= 1'b1;
                        pc_inc    <= 1'b1;
                        fetch_cnt <= fetch_cnt + 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state     <= S_IDLE;
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
`endif
                    end else begin
                        state     <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end

                S_LOAD: begin
                    // The instruction register captures the data this cycle.
                    // From the next cycle it is offered to decode.
                    state       <= S_HOLD;
                    instr_valid <= 1'b1;
                end

                S_HOLD: begin
                    // Hold the instruction until decode takes it. Only then
                    // does stall decide between idling and fetching again.
                    if (dec_ready) begin
                        instr_valid <= 1'b0;
                        if (stall) begin
                            state    <= S_IDLE;
                        end else begin
                            state    <= S_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc_in;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized self-checking bench for fetch_ctrl.
//
// The bench plays both memory and decode, and decides in advance how each
// fetch unfolds: the ack delay, the decode hold time, and stall at accept.
// From that plan it knows the expected output of every cycle. The launch
// address is pushed into exp_q when the bench drives it, and popped when
// that fetch is checked. Inputs the controller must ignore carry random noise.
// Define FETCH_TIMEOUT_EN to exercise the memory-wait timeout.

module tb_fetch_ctrl;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 10;
  localparam int TO      = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  // ---------------------------------------------------------------- clock/reset
  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic [ADDR_W-1:0] pc_in;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              ir_load;
  logic              pc_inc;
  logic              instr_valid;
  logic              dec_ready;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              fetch_err;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_W        (ADDR_W),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_in      (pc_in),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .fetch_cnt  (fetch_cnt),
    .fetch_err  (fetch_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  int                exp_cnt;
  logic              exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit req, input bit ld, input bit iv,
                            input bit chk_cnt);
    check({tag, ".mem_req"},     32'(mem_req),     32'(req));
    check({tag, ".ir_load"},     32'(ir_load),     32'(ld));
    check({tag, ".pc_inc"},      32'(pc_inc),      32'(ld));
    check({tag, ".instr_valid"}, 32'(instr_valid), 32'(iv));
    check({tag, ".mem_addr"},    32'(mem_addr),    32'(exp_addr));
    check({tag, ".fetch_err"},   32'(fetch_err),   32'(exp_err));
    // The count is compared from HOLD onward. Whether it steps on entry to
    // LOAD or on leaving it is not observable from outside.
    if (chk_cnt) check({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(exp_cnt));
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    mem_ack   = 1'($urandom_range(0, 1));
    dec_ready = 1'($urandom_range(0, 1));
    stall     = 1'($urandom_range(0, 1));
    pc_in     = $urandom;
  endtask

  // Spend n cycles idle with stall high, then one cycle with stall low that
  // launches a fetch of nxt.
  task automatic idle_phase(input int n, input logic [ADDR_W-1:0] nxt);
    for (int i = 0; i <= n; i++) begin
      check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b1);
      noise();
      if (i == n) begin
        stall = 1'b0;
        pc_in = nxt;
        exp_q.push_back(nxt);
      end else begin
        stall = 1'b1;
      end
      tick();
    end
  endtask

  // One complete fetch. Memory acks after d extra wait cycles. Decode accepts
  // after h extra hold cycles, with stall = s. If s is 0, the next fetch of
  // nxt launches on that same accept.
  task automatic fetch(input int d, input int h, input bit s, input logic [ADDR_W-1:0] nxt);
    if (exp_q.size() > 0) exp_addr = exp_q.pop_front();
    for (int j = 0; j <= d; j++) begin
      check_outs("req", 1'b1, 1'b0, 1'b0, 1'b1);
      noise();
      mem_ack = (j == d);
      tick();
    end
    exp_cnt = (exp_cnt + 1) % CNT_MOD;
    check_outs("load", 1'b0, 1'b1, 1'b0, 1'b0);
    noise();
    tick();
    for (int j = 0; j <= h; j++) begin
      check_outs("hold", 1'b0, 1'b0, 1'b1, 1'b1);
      noise();
      dec_ready = (j == h);
      if (j == h) begin
        stall = s;
        if (!s) begin
          pc_in = nxt;
          exp_q.push_back(nxt);
        end
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset     = 1'b1;
    stall     = 1'b1;
    mem_ack   = 1'b0;
    dec_ready = 1'b0;
    pc_in     = '0;
    exp_addr  = '0;
    exp_cnt   = 0;
    exp_err   = 1'b0;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    // Best case: ack in REQ. The load pulse comes one cycle later and
    // instr_valid the cycle after that.
    idle_phase(0, 32'h100);
    fetch(0, 0, 1'b1, '0);

    // Ack delayed four cycles: five request cycles on a stable address.
    idle_phase(1, 32'h200);
    fetch(4, 0, 1'b1, '0);

    // Decode stalls ten cycles. Stall is high at accept, so the controller
    // returns to IDLE.
    idle_phase(0, 32'h300);
    fetch(0, 10, 1'b1, '0);

    // Back-to-back fetches with immediate ack: one instruction every 3 cycles.
    idle_phase(0, 32'h400);
    fetch(0, 0, 1'b0, 32'h404);
    fetch(0, 0, 1'b0, 32'h408);
    fetch(0, 0, 1'b1, '0);

    // Reset arrives while the read is still waiting. A late ack must not load.
    idle_phase(0, 32'h500);
    if (exp_q.size() > 0) exp_addr = exp_q.pop_front();
    for (int j = 0; j < 2; j++) begin
      check_outs("req_abort", 1'b1, 1'b0, 1'b0, 1'b1);
      noise();
      mem_ack = 1'b0;
      tick();
    end
    reset   = 1'b1;
    mem_ack = 1'b0;
    tick();
    exp_addr = '0;
    exp_cnt  = 0;
    check_outs("rst_in_wait", 1'b0, 1'b0, 1'b0, 1'b1);
    reset   = 1'b0;
    stall   = 1'b1;
    mem_ack = 1'b1;
    tick();
    check_outs("late_ack", 1'b0, 1'b0, 1'b0, 1'b1);
    mem_ack = 1'b0;
    tick();

`ifdef FETCH_TIMEOUT_EN
    // Memory never acks: after TO request cycles the read is abandoned.
    // fetch_err then holds the controller in IDLE until reset.
    idle_phase(0, 32'h600);
    if (exp_q.size() > 0) exp_addr = exp_q.pop_front();
    for (int j = 0; j < TO; j++) begin
      check_outs("to_wait", 1'b1, 1'b0, 1'b0, 1'b1);
      noise();
      mem_ack = 1'b0;
      tick();
    end
    exp_err = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check_outs("to_idle", 1'b0, 1'b0, 1'b0, 1'b1);
      noise();
      stall = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    exp_err  = 1'b0;
    exp_addr = '0;
    exp_cnt  = 0;
    check_outs("to_reset", 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    stall = 1'b1;
    tick();
`else
    // No timeout in this build: a long wait keeps requesting, then completes.
    idle_phase(0, 32'h600);
    fetch(30, 1, 1'b1, '0);
`endif

    // Random fetches, enough to wrap the retired-fetch counter.
    idle_phase($urandom_range(0, 2), $urandom);
    for (int k = 0; k < 1100; k++) begin
      int                d;
      int                h;
      bit                s;
      logic [ADDR_W-1:0] nxt;
      d   = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 6) : $urandom_range(0, 1);
      h   = $urandom_range(0, 3);
      s   = (k == 1099) || ($urandom_range(0, 4) == 0);
      nxt = $urandom;
      fetch(d, h, s, nxt);
      if (s && k != 1099) idle_phase($urandom_range(0, 3), $urandom);
    end
    check_outs("final_idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // ------------------------------------------------------------ final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d of %0d checks failed so far", n_fail, n_tests);
    $fatal(1, "tb_fetch_ctrl stopped by watchdog");
  end

endmodule
